// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC SPI target and its matching controller:
// command opcodes, register addresses, FSM state encoding and the channel
// search helpers used by the auto-sequencer.
package adc_spi_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_READ   = 8'h10;
    localparam logic [7:0] OP_WRITE  = 8'h08;
    localparam logic [7:0] OP_SETBIT = 8'h18;
    localparam logic [7:0] OP_CLRBIT = 8'h20;

    localparam logic [7:0] ADDR_SYSTEM_STATUS   = 8'h00;
    localparam logic [7:0] ADDR_GENERAL_CFG     = 8'h01;
    localparam logic [7:0] ADDR_DATA_CFG        = 8'h02;
    localparam logic [7:0] ADDR_SEQUENCE_CFG    = 8'h10;
    localparam logic [7:0] ADDR_AUTO_SEQ_CH_SEL = 8'h12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_EXEC  = 2'd3
    } spi_state_t;

    // Lowest channel enabled in the mask, or 0 when the mask is empty.
    function automatic logic [2:0] lowest_set(input logic [7:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Next enabled channel strictly after cur, wrapping 7 -> 0. A mask that
    // only holds cur lands back on cur; an empty mask yields 0.
    function automatic logic [2:0] next_set_above(input logic [7:0] mask,
                                                   input logic [2:0] cur);
        logic [2:0] idx;
        logic [2:0] cand;
        logic       found;
        idx   = 3'd0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cand = cur + 3'(i);
            if (!found && mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/spi_target_shifter.sv
// Bit-level half of the SPI target: synchronises csel/sclk/mosi into clk,
// finds their edges, and runs the 24-bit rx/tx shift registers plus the
// saturating bit counter. Frame start/end are reported to the parent FSM,
// which decides when to load tx and when shifting is allowed.
module spi_target_shifter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csel,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        load,
    input  logic        shift_en,
    input  logic [23:0] tx_load_value,
    output logic        miso,
    output logic        frame_start,
    output logic        frame_end,
    output logic [23:0] rx,
    output logic [4:0]  bitcnt
);

    logic [SYNC_STAGES-1:0] csel_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   csel_q;
    logic                   sclk_q;
    logic                   csel_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   csel_edge;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic [23:0]            tx;

    // The synchroniser chains and edge history are deliberately left out of
    // reset so a reset in mid-frame cannot fake a csel falling edge.
    always_ff @(posedge clk) begin
        csel_sync <= {csel_sync[SYNC_STAGES-2:0], csel};
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        csel_q    <= csel_sync[SYNC_STAGES-1];
        sclk_q    <= sclk_sync[SYNC_STAGES-1];
    end

    // Edges come from the synchronised copies; a csel edge masks any sclk
    // edge in the same cycle.
    always_comb begin
        csel_s      = csel_sync[SYNC_STAGES-1];
        sclk_s      = sclk_sync[SYNC_STAGES-1];
        mosi_s      = mosi_sync[SYNC_STAGES-1];
        frame_start = csel_q & ~csel_s;
        frame_end   = ~csel_q & csel_s;
        csel_edge   = frame_start | frame_end;
        sclk_rise   = ~sclk_q & sclk_s & ~csel_edge;
        sclk_fall   = sclk_q & ~sclk_s & ~csel_edge;
    end

    // Mode 0 shifting: capture mosi on sclk rise, present the next tx bit on
    // sclk fall; the first tx bit is put on miso at load time.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx     <= '0;
            tx     <= '0;
            bitcnt <= '0;
            miso   <= 1'b0;
        end else if (load) begin
            rx     <= '0;
            tx     <= tx_load_value;
            bitcnt <= '0;
            miso   <= tx_load_value[23];
        end else if (shift_en) begin
            if (sclk_rise) begin
                rx <= {rx[22:0], mosi_s};
                if (bitcnt != 5'd31) bitcnt <= bitcnt + 5'd1;
            end
            if (sclk_fall) begin
                tx   <= {tx[22:0], 1'b0};
                miso <= tx[22];
            end
        end
    end

endmodule

// File: rtl/adc_spi_target.sv
// Emulated 8-channel 12-bit ADC on the target side of SPI. Decodes 24-bit
// command frames and 16-bit readout frames, keeps the small register file
// and drives read data or {sample, channel} words back on miso.
// Optional feature macro: ADC_SPI_TARGET_CAL_DELAY_EN (timed GENERAL_CFG.CAL).
module adc_spi_target
    import adc_spi_pkg::*;
#(
    parameter int CAL_CYCLES  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csel,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic [3:0]  sample_chan,
    input  logic [11:0] sample_data,
    output logic        frame_err
);

    spi_state_t  state;
    spi_state_t  state_next;
    logic        load;
    logic        shift_en;
    logic        frame_start;
    logic        frame_end;
    logic [23:0] rx;
    logic [4:0]  bitcnt;
    logic [23:0] tx_load_value;

    logic        bor;
    logic [7:0]  data_cfg;
    logic [7:0]  seq_cfg;
    logic [7:0]  ch_sel;
    logic [2:0]  chan_idx;
    logic        rd_pending;
    logic [7:0]  rd_byte;
    logic        cal_bit;
    logic        seq_active;

    logic        exec;
    logic        cmd_frame;
    logic        ro_frame;
    logic        bad_frame;
    logic [7:0]  opcode;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [7:0]  cur_val;
    logic [7:0]  wr_val;
    logic        do_write;
    logic        do_read;

    // Parameter sanity: a single-flop synchroniser or an empty CAL window is
    // not a supported configuration; this block only documents the limit.
    generate
        if (SYNC_STAGES < 2 || CAL_CYCLES < 1) begin : g_unsupported_params
        end
    endgenerate

    spi_target_shifter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shifter (
        .clk           (clk),
        .reset         (reset),
        .csel          (csel),
        .sclk          (sclk),
        .mosi          (mosi),
        .load          (load),
        .shift_en      (shift_en),
        .tx_load_value (tx_load_value),
        .miso          (miso),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .rx            (rx),
        .bitcnt        (bitcnt)
    );

    // Frame state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Frame sequencing: IDLE -> LOAD -> SHIFT -> EXEC -> IDLE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        exec       = 1'b0;
        case (state)
            ST_IDLE:  if (frame_start) state_next = ST_LOAD;
            ST_LOAD: begin
                load       = 1'b1;
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (frame_end) state_next = ST_EXEC;
            end
            ST_EXEC: begin
                exec       = 1'b1;
                state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Reply selection for the frame about to start.
    always_comb begin
        seq_active    = (seq_cfg[1:0] == 2'b01) && seq_cfg[4];
        tx_load_value = '0;
        if (rd_pending)      tx_load_value = {rd_byte, 16'h0000};
        else if (seq_active) tx_load_value = {sample_data, 1'b0, chan_idx, 8'h00};
    end

    // Register read view; unmapped addresses and self-clearing bits read 0.
    always_comb begin
        cur_val = 8'h00;
        case (addr)
            ADDR_SYSTEM_STATUS:   cur_val = {7'b0, bor};
            ADDR_GENERAL_CFG:     cur_val = {6'b0, cal_bit, 1'b0};
            ADDR_DATA_CFG:        cur_val = data_cfg;
            ADDR_SEQUENCE_CFG:    cur_val = seq_cfg;
            ADDR_AUTO_SEQ_CH_SEL: cur_val = ch_sel;
            default:              cur_val = 8'h00;
        endcase
    end

    // Command decode at EXEC; bit-set/clear become a write of the merged value.
    always_comb begin
        opcode    = rx[23:16];
        addr      = rx[15:8];
        data      = rx[7:0];
        cmd_frame = exec && (bitcnt == 5'd24);
        ro_frame  = exec && (bitcnt == 5'd16);
        bad_frame = exec && (bitcnt != 5'd24) && (bitcnt != 5'd16);
        do_write  = 1'b0;
        do_read   = 1'b0;
        wr_val    = cur_val;
        if (cmd_frame) begin
            case (opcode)
                OP_NOP:    ;
                OP_READ:   do_read = 1'b1;
                OP_WRITE: begin
                    do_write = 1'b1;
                    wr_val   = data;
                end
                OP_SETBIT: begin
                    do_write = 1'b1;
                    wr_val   = cur_val | data;
                end
                OP_CLRBIT: begin
                    do_write = 1'b1;
                    wr_val   = cur_val & ~data;
                end
                default:   ;
            endcase
        end
    end

    // Register file, pending read, channel pointer and the frame error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            bor        <= 1'b1;
            data_cfg   <= 8'h00;
            seq_cfg    <= 8'h00;
            ch_sel     <= 8'h00;
            chan_idx   <= 3'd0;
            rd_pending <= 1'b0;
            rd_byte    <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= bad_frame;
            if (load) rd_pending <= 1'b0;
            if (do_read) begin
                rd_byte    <= cur_val;
                rd_pending <= 1'b1;
            end
            if (do_write) begin
                case (addr)
                    ADDR_SYSTEM_STATUS: if (wr_val[0]) bor <= 1'b0;
                    ADDR_GENERAL_CFG: begin
                        if (wr_val[0]) begin
                            bor        <= 1'b1;
                            data_cfg   <= 8'h00;
                            seq_cfg    <= 8'h00;
                            ch_sel     <= 8'h00;
                            chan_idx   <= 3'd0;
                            rd_pending <= 1'b0;
                        end
                    end
                    ADDR_DATA_CFG:        data_cfg <= wr_val;
                    ADDR_SEQUENCE_CFG: begin
                        seq_cfg <= wr_val;
                        if (!seq_cfg[4] && wr_val[4]) chan_idx <= lowest_set(ch_sel);
                    end
                    ADDR_AUTO_SEQ_CH_SEL: ch_sel <= wr_val;
                    default:              ;
                endcase
            end
            if (ro_frame && seq_active) chan_idx <= next_set_above(ch_sel, chan_idx);
        end
    end

    assign sample_chan = {1'b0, chan_idx};

`ifdef ADC_SPI_TARGET_CAL_DELAY_EN
    localparam int CAL_W = $clog2(CAL_CYCLES + 1);
    logic [CAL_W-1:0] cal_cnt;

    // CAL window counter; a new CAL=1 write restarts it, a RST write kills it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cal_cnt <= '0;
        end else if (do_write && addr == ADDR_GENERAL_CFG && wr_val[0]) begin
            cal_cnt <= '0;
        end else if (do_write && addr == ADDR_GENERAL_CFG && wr_val[1]) begin
            cal_cnt <= CAL_W'(CAL_CYCLES);
        end else if (cal_cnt != '0) begin
            cal_cnt <= cal_cnt - 1'b1;
        end
    end

    assign cal_bit = (cal_cnt != '0);
`else
    // Without the timed window CAL is gone before any later frame can read it.
    assign cal_bit = 1'b0;
`endif

endmodule

// File: tb/tb_adc_spi_target.sv
// Directed bench for adc_spi_target: drives real SPI frames, predicts every
// miso word, frame_err pulse and sample_chan value from a register-level
// model of the emulated ADC, and pins that model with literal expectations.
module tb_adc_spi_target;

    localparam int HALF = 8;

    logic        clk;
    logic        reset;
    logic        csel;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [3:0]  sample_chan;
    logic [11:0] sample_data;
    logic        frame_err;

    int          n_cmp;
    int          n_bad;
    int          err_cycles;
    logic        check_en;
    logic [23:0] last_rx;

    // Register-level model of the target.
    logic        m_bor;
    logic [7:0]  m_data;
    logic [7:0]  m_seq;
    logic [7:0]  m_chsel;
    logic [2:0]  m_chan;
    logic        m_pending;
    logic [7:0]  m_rd;

    adc_spi_target #(
        .CAL_CYCLES  (64),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .csel        (csel),
        .sclk        (sclk),
        .mosi        (mosi),
        .miso        (miso),
        .sample_chan (sample_chan),
        .sample_data (sample_data),
        .frame_err   (frame_err)
    );

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles with frame_err high so pulse width can be checked per frame.
    always @(negedge clk) begin
        if (frame_err) err_cycles++;
    end

    // Between frames sample_chan must track the model and frame_err stay low.
    always @(negedge clk) begin
        if (check_en) begin
            n_cmp++;
            if (sample_chan !== {1'b0, m_chan}) begin
                n_bad++;
                if (n_bad < 20) $display("[TB] FAIL chan_track: got %0d, expected %0d", sample_chan, m_chan);
            end
            n_cmp++;
            if (frame_err !== 1'b0) begin
                n_bad++;
                if (n_bad < 20) $display("[TB] FAIL idle_frame_err: got %b, expected 0", frame_err);
            end
        end
    end

    task automatic check_output(input string name, input logic [23:0] actual, input logic [23:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_bor     = 1'b1;
        m_data    = 8'h00;
        m_seq     = 8'h00;
        m_chsel   = 8'h00;
        m_chan    = 3'd0;
        m_pending = 1'b0;
        m_rd      = 8'h00;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] ad);
        case (ad)
            8'h00:   return {7'b0, m_bor};
            8'h01:   return 8'h00;  // CAL window is far shorter than a frame
            8'h02:   return m_data;
            8'h10:   return m_seq;
            8'h12:   return m_chsel;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] ad, input logic [7:0] v);
        logic [2:0] low;
        case (ad)
            8'h00: if (v[0]) m_bor = 1'b0;
            8'h01: if (v[0]) begin
                m_bor = 1'b1; m_data = 0; m_seq = 0; m_chsel = 0; m_chan = 0; m_pending = 0;
            end
            8'h02: m_data = v;
            8'h10: begin
                if (!m_seq[4] && v[4]) begin
                    low = 3'd0;
                    for (int i = 7; i >= 0; i--) if (m_chsel[i]) low = 3'(i);
                    m_chan = low;
                end
                m_seq = v;
            end
            8'h12: m_chsel = v;
            default: ;
        endcase
    endtask

    task automatic model_frame(input int nbits, input logic [23:0] word,
                               output logic [23:0] exp_tx, output logic exp_err);
        logic [7:0] op, ad, dt, cur;
        logic [2:0] nxt;
        exp_err = 1'b0;
        if (m_pending) begin
            exp_tx    = {m_rd, 16'h0000};
            m_pending = 1'b0;
        end else if (m_seq[1:0] == 2'b01 && m_seq[4]) begin
            exp_tx = {sample_data, 1'b0, m_chan, 8'h00};
        end else begin
            exp_tx = 24'h0;
        end
        if (nbits == 24) begin
            op  = word[23:16];
            ad  = word[15:8];
            dt  = word[7:0];
            cur = model_read(ad);
            case (op)
                8'h10: begin m_rd = cur; m_pending = 1'b1; end
                8'h08: model_write(ad, dt);
                8'h18: model_write(ad, cur | dt);
                8'h20: model_write(ad, cur & ~dt);
                default: ;
            endcase
        end else if (nbits == 16) begin
            if (m_seq[1:0] == 2'b01 && m_seq[4]) begin
                nxt = 3'd0;
                for (int step = 8; step >= 1; step--)
                    if (m_chsel[(int'(m_chan) + step) % 8]) nxt = 3'((int'(m_chan) + step) % 8);
                m_chan = nxt;
            end
        end else begin
            exp_err = 1'b1;
        end
    endtask

    // One full SPI frame of nbits (word right-aligned, sent MSB first).
    task automatic apply_stimulus(input string name, input int nbits, input logic [23:0] word);
        logic [23:0] exp_tx;
        logic [23:0] got;
        logic        exp_err;
        model_frame(nbits, word, exp_tx, exp_err);
        check_en   = 1'b0;
        err_cycles = 0;
        got        = 24'h0;
        @(negedge clk);
        csel = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = word[i];
            repeat (HALF) @(negedge clk);
            got  = {got[22:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        csel = 1'b1;
        repeat (HALF) @(negedge clk);
        last_rx = got;
        check_output({name, "/miso"}, got, exp_tx >> (24 - nbits));
        check_output({name, "/frame_err_cycles"}, 24'(err_cycles), exp_err ? 24'd1 : 24'd0);
        check_en = 1'b1;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        err_cycles  = 0;
        check_en    = 1'b0;
        last_rx     = 24'h0;
        reset       = 1'b1;
        csel        = 1'b1;
        sclk        = 1'b0;
        mosi        = 1'b0;
        sample_data = 12'hABC;
        model_reset();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset/miso", 24'(miso), 24'd0);
        check_output("reset/sample_chan", 24'(sample_chan), 24'd0);
        check_output("reset/frame_err", 24'(frame_err), 24'd0);
        check_en = 1'b1;

        $display("[TB] BOR read and write-1-to-clear");
        apply_stimulus("rd_status0", 24, 24'h100000);
        apply_stimulus("rd_status1", 24, 24'h100000);
        check_output("bor_after_reset", 24'(last_rx[23:16]), 24'h01);
        apply_stimulus("w1c_bor", 24, 24'h080001);
        apply_stimulus("rd_status2", 24, 24'h100000);
        apply_stimulus("nop_a", 24, 24'h000000);
        check_output("bor_cleared", 24'(last_rx[23:16]), 24'h00);

        $display("[TB] CAL write then poll");
        apply_stimulus("wr_cal", 24, 24'h080102);
        apply_stimulus("rd_gen", 24, 24'h100100);
        apply_stimulus("nop_b", 24, 24'h000000);
        check_output("cal_poll", 24'(last_rx[23:16]), 24'h00);

        $display("[TB] Auto-sequence across mask 0x7F");
        apply_stimulus("wr_chsel", 24, 24'h08127F);
        apply_stimulus("wr_seq", 24, 24'h081011);
        for (int k = 0; k < 8; k++) begin
            apply_stimulus("readout", 16, 24'h000000);
            check_output("readout_word", 24'(last_rx[15:0]), 24'hABC0 + 24'(k % 7));
        end

        $display("[TB] Empty channel mask");
        apply_stimulus("wr_chsel0", 24, 24'h081200);
        apply_stimulus("seq_off", 24, 24'h081001);
        apply_stimulus("seq_on", 24, 24'h081011);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus("readout_m0", 16, 24'h000000);
            check_output("readout_mask0", 24'(last_rx[15:0]), 24'hABC0);
        end

        $display("[TB] Short frame");
        apply_stimulus("wr_chsel7f", 24, 24'h08127F);
        apply_stimulus("readout_c0", 16, 24'h000000);
        apply_stimulus("readout_c1", 16, 24'h000000);
        apply_stimulus("bad13", 13, 24'h001234);
        check_output("bad13_chan", 24'(sample_chan), 24'd2);
        apply_stimulus("readout_c2", 16, 24'h000000);
        check_output("after_bad_word", 24'(last_rx[15:0]), 24'hABC2);

        $display("[TB] Bit set and clear on DATA_CFG");
        apply_stimulus("setbit", 24, 24'h180281);
        apply_stimulus("clrbit", 24, 24'h200201);
        apply_stimulus("rd_data", 24, 24'h100200);
        apply_stimulus("nop_c", 24, 24'h000000);
        check_output("data_cfg_bits", 24'(last_rx[23:16]), 24'h80);

        $display("[TB] Soft reset through GENERAL_CFG.RST");
        apply_stimulus("soft_rst", 24, 24'h080101);
        check_output("soft_rst_chan", 24'(sample_chan), 24'd0);
        apply_stimulus("rd_status3", 24, 24'h100000);
        apply_stimulus("nop_d", 24, 24'h000000);
        check_output("bor_after_rst", 24'(last_rx[23:16]), 24'h01);

        $display("[TB] Reset asserted mid-frame");
        apply_stimulus("wr_data5a", 24, 24'h08025A);
        check_en   = 1'b0;
        err_cycles = 0;
        @(negedge clk);
        csel = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
            mosi = i[0];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        csel = 1'b1;
        repeat (HALF) @(negedge clk);
        model_reset();
        check_output("midreset/frame_err_cycles", 24'(err_cycles), 24'd0);
        check_output("midreset/chan", 24'(sample_chan), 24'd0);
        check_en = 1'b1;
        apply_stimulus("rd_data2", 24, 24'h100200);
        apply_stimulus("nop_e", 24, 24'h000000);
        check_output("data_after_reset", 24'(last_rx[23:16]), 24'h00);

        check_en = 1'b0;
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_spi_target.md
Name: adc_spi_target

Overview:
- SPI responder that emulates the 8-channel 12-bit ADC register/readout protocol on the target side of the bus.
- Decodes 24-bit command frames (opcode, address, data) and 16-bit NOP readout frames.
- Holds a small register file and returns read data and {sample, channel} words on miso.
- Used as the loopback/bench counterpart to our ADC SPI controller, and as an emulated ADC exposed over the Logicbone header.

Parameters:
- CAL_CYCLES, 64, clk cycles that GENERAL_CFG.CAL stays set after being written 1 (only with the optional feature).
- SYNC_STAGES, 2, synchroniser depth on csel/sclk/mosi; must be at least 2.

Ports:
- clk  in  1  system clock; sclk must be no faster than clk/4.
- reset  in  1  synchronous, active-high reset.
- csel  in  1  SPI chip select, active low.
- sclk  in  1  SPI clock, mode 0 (idles low).
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out, MSB first.
- sample_chan  out  4  channel whose conversion is returned in the next readout frame.
- sample_data  in  12  conversion result for sample_chan; captured on the csel falling edge.
- frame_err  out  1  one-cycle pulse when a frame ends with a bit count other than 16 or 24.

Behaviour:
- Clocking: one clock domain. Synchronise csel, sclk and mosi with SYNC_STAGES flops. Detect sclk and csel edges from the synchronised copies.
- Reset values:
  - miso=0, sample_chan=0, frame_err=0.
  - Registers zero, except SYSTEM_STATUS.BOR=1.
  - FSM in IDLE.
- FSM states: IDLE, LOAD, SHIFT, EXEC.
  - IDLE -> LOAD on csel falling edge.
  - LOAD (1 cycle): build tx[23:0], then -> SHIFT.
    - If a read is pending, tx = {rd_byte, 16'h0} and the pending flag clears.
    - Else if SEQUENCE_CFG[1:0]==2'b01 and SEQUENCE_CFG[4]==1, tx = {sample_data, sample_chan, 8'h00}.
    - Else tx = 0.
    - miso = tx[23].
  - SHIFT: on each sclk rising edge, shift mosi into rx and increment bitcnt (5 bits, saturates at 31). On each sclk falling edge, drive the next tx bit on miso.
  - SHIFT -> EXEC on csel rising edge. EXEC (1 cycle) -> IDLE.
- EXEC decode by bitcnt:
  - 24: opcode=rx[23:16], addr=rx[15:8], data=rx[7:0].
    - READ (0x10): rd_byte=reg[addr], set pending.
    - WRITE (0x08): reg[addr]=data.
    - SETBIT (0x18): reg |= data.
    - CLRBIT (0x20): reg &= ~data.
    - NOP: no action. Any other opcode: no action.
  - 16: readout frame. If sequencing is active, advance sample_chan to the next set bit of AUTO_SEQ_CH_SEL above its current value, wrapping from 7 back to 0. If the mask is 0, sample_chan=0.
  - Any other count: pulse frame_err; no register, pending-read or sample_chan change.
- Register map (unmapped addresses read 0 and ignore writes):
  - 0x00 SYSTEM_STATUS: bit0 BOR is write-1-to-clear; other bits read 0.
  - 0x01 GENERAL_CFG:
    - bit0 RST is self-clearing. Writing 1 resets all registers, sets BOR=1, sets sample_chan=0 and clears the pending read.
    - bit1 CAL: see Optional Feature.
  - 0x02 DATA_CFG: 8-bit storage only.
  - 0x10 SEQUENCE_CFG: 8-bit. Writing it with bit4 rising sets sample_chan to the lowest set bit of the mask.
  - 0x12 AUTO_SEQ_CH_SEL: 8-bit mask.
- Boundary cases:
  - csel rising edge mid-byte: handled as an odd bit count, i.e. frame_err.
  - csel edge in the same cycle as an sclk edge: the csel edge wins; that sclk edge is ignored.
  - reset asserted during a frame: return to IDLE and ignore the rest of the frame until the next csel falling edge.
  - A READ of a register written in the same frame's EXEC is impossible; a read always returns the value at its own EXEC.

Optional Feature:
- Macro: ADC_SPI_TARGET_CAL_DELAY_EN.
- Defined: writing CAL=1 starts a counter; CAL reads 1 for CAL_CYCLES clk cycles, then clears. A new CAL=1 write while counting restarts the count.
- Undefined: CAL clears at the EXEC following the write, so the first subsequent read returns 0. The CAL_CYCLES parameter is unused.

Decomposition:
- Package adc_spi_pkg: opcode constants (NOP, READ, WRITE, SETBIT, CLRBIT), register address constants, and FSM state encodings. Shared with the controller.
- Sub-module spi_target_shifter: synchronisers, edge detect, 24-bit rx/tx shift registers, bitcnt. Reports frame start, frame end and rx/bitcnt to the parent.

Test Plan:
- After reset, send 24-bit {0x10,0x00,0x00} then a second read frame -> second frame's first byte on miso = 0x01 (BOR); then write {0x08,0x00,0x01} and read back -> 0x00.
- Write {0x08,0x01,0x02}, then poll GENERAL_CFG:
  - with macro and CAL_CYCLES=64: bit1 reads 1 until 64 clk cycles have elapsed, then 0.
  - without macro: first poll returns 0x00.
- Write CH_SEL=0x7F and SEQUENCE_CFG=0x11, hold sample_data=0xABC -> successive 16-bit frames return words 0xABC0, 0xABC1 … 0xABC6, then 0xABC0 (wrap).
- Write CH_SEL=0x00 with sequencing on -> every readout frame returns channel 0 and sample_chan stays 0.
- Send a 13-bit frame -> frame_err pulses for exactly 1 cycle; registers, pending read and sample_chan unchanged.
- Send SETBIT {0x18,0x02,0x81}, then CLRBIT {0x20,0x02,0x01}, then read DATA_CFG -> 0x80.
